// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants for the SPI-mode SD card responder
// Purpose: command indices, R1 bit positions, FSM state codes, frame length
// and the CRC7 polynomial used by sd_crc7 and sd_spi_responder.
package sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  // R1 = {0, param, addr, erase_seq, crc_err, illegal, erase_rst, idle}
  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam int FRAME_BITS = 48;

  // x^7 + x^3 + 1 without the implicit x^7 term
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef logic [1:0] state_t;
  localparam state_t ST_HUNT = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_NCR  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 generator/checker for SD command frames
// Purpose: bit-serial CRC7 (poly x^7+x^3+1, init 0), one bit per enabled clock.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   return the remainder to 0 (wins over enable)
//   enable in   fold data into the remainder this clock
//   data   in   next message bit, MSB first
//   crc    out  current 7-bit remainder
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data,
  output logic [6:0] crc
);

  logic feedback;
  assign feedback = data ^ crc[6];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - card-side SPI-mode SD command responder
// Purpose: oversamples SPI mode 0, receives 48-bit command frames, checks
// CRC7, tracks minimal card init state and returns R1/R3/R7 responses.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   sclk, cs_n, mosi     asynchronous SPI inputs from the host
//   miso                 card-to-host data, idles high
//   cmd_valid            one-clock pulse per complete received frame
//   cmd_index, cmd_arg   fields of the last received frame
//   card_idle            card still in idle state (R1 bit 0)
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int          NCR_BYTES  = 1,
  parameter int          INIT_POLLS = 2,
  parameter logic [31:0] OCR        = 32'hC0FF8000,
  parameter bit          CHECK_CRC  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_idle
);

  localparam int NCR_BITS = NCR_BYTES * 8;

  logic [2:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_active, mosi_bit;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_active = ~cs_sync[1];
  assign mosi_bit  = mosi_sync[1];

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [45:0] frame;     // bits 1..46 of the frame; the start bit is implied
  logic [15:0] ncr_cnt;
  logic [5:0]  resp_cnt;
  logic [5:0]  resp_last;
  logic [39:0] resp_sr;
  logic        app_flag;
  logic [7:0]  poll_cnt;
  logic [6:0]  crc_val;

  logic        start_bit, frame_done, crc_clear, crc_en;
  logic [46:0] frame_full;  // bits 1..47 including the bit arriving now

  assign start_bit  = (state == ST_HUNT) && cs_active && sclk_rise && !mosi_bit;
  assign frame_done = (state == ST_CMD) && sclk_rise && (bit_cnt == 6'(FRAME_BITS - 1));
  assign frame_full = {frame, mosi_bit};
  assign crc_clear  = (state == ST_HUNT) && !start_bit;
  // CRC covers start bit, transmission bit, index and argument (bits 0..39)
  assign crc_en     = start_bit || ((state == ST_CMD) && sclk_rise && (bit_cnt < 6'd40));

  sd_crc7 u_crc7 (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (mosi_bit),
    .crc    (crc_val)
  );

  logic [5:0]  rx_index;
  logic [31:0] rx_arg;
  assign rx_index = frame_full[45:40];
  assign rx_arg   = frame_full[39:8];

  logic        crc_fail, illegal, is_long, nxt_idle, nxt_app;
  logic [7:0]  nxt_polls, r1;
  logic [31:0] tail;
  logic [39:0] resp_word;

  always_comb begin
    nxt_idle  = card_idle;
    nxt_app   = app_flag;
    nxt_polls = poll_cnt;
    illegal   = 1'b0;
    is_long   = 1'b0;
    tail      = 32'h0;
    // The whole last byte is compared, so a missing end bit counts as a CRC error
    crc_fail  = (CHECK_CRC && (frame_full[7:0] != {crc_val, 1'b1})) || !frame_full[46];
    if (!crc_fail) begin
      nxt_app = 1'b0;
      if (rx_index == CMD0) begin
        nxt_idle  = 1'b1;
        nxt_polls = 8'd0;
      end else if (rx_index == CMD8) begin
        is_long = 1'b1;
        tail    = {16'h0000, 4'h0, rx_arg[11:8], rx_arg[7:0]};
      end else if (rx_index == CMD55) begin
        nxt_app = 1'b1;
      end else if ((rx_index == CMD41) && app_flag) begin
        if (poll_cnt < 8'(INIT_POLLS)) nxt_polls = poll_cnt + 8'd1;
        if (nxt_polls >= 8'(INIT_POLLS)) nxt_idle = 1'b0;
      end else if (rx_index == CMD58) begin
        is_long = 1'b1;
        tail    = OCR;
      end else begin
        illegal = 1'b1;
      end
    end
    r1             = 8'h00;
    r1[R1_IDLE]    = nxt_idle;
    r1[R1_ILLEGAL] = illegal;
    r1[R1_CRC_ERR] = crc_fail;
    resp_word      = {r1, tail};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_HUNT;
      bit_cnt   <= 6'd0;
      frame     <= '0;
      ncr_cnt   <= 16'd0;
      resp_cnt  <= 6'd0;
      resp_last <= 6'd0;
      resp_sr   <= '0;
      miso      <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
      card_idle <= 1'b1;
      app_flag  <= 1'b0;
      poll_cnt  <= 8'd0;
    end else begin
      cmd_valid <= 1'b0;
      if (!cs_active) begin
        state   <= ST_HUNT;
        miso    <= 1'b1;
        bit_cnt <= 6'd0;
      end else begin
        case (state)
          ST_HUNT: begin
            // Returning to 1 on a fall keeps the last response bit valid for its rise
            if (sclk_fall) miso <= 1'b1;
            if (start_bit) begin
              state   <= ST_CMD;
              bit_cnt <= 6'd1;
              frame   <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              frame   <= frame_full[45:0];
              bit_cnt <= bit_cnt + 6'd1;
            end
            if (frame_done) begin
              cmd_valid <= 1'b1;
              cmd_index <= rx_index;
              cmd_arg   <= rx_arg;
              card_idle <= nxt_idle;
              app_flag  <= nxt_app;
              poll_cnt  <= nxt_polls;
              resp_sr   <= resp_word;
              resp_last <= is_long ? 6'd39 : 6'd7;
              ncr_cnt   <= 16'd0;
              state     <= ST_NCR;
            end
          end
          ST_NCR: begin
            if (sclk_fall) begin
              miso <= 1'b1;
              if (ncr_cnt == 16'(NCR_BITS - 1)) begin
                state    <= ST_RESP;
                resp_cnt <= 6'd0;
              end else begin
                ncr_cnt <= ncr_cnt + 16'd1;
              end
            end
          end
          default: begin
            if (sclk_fall) begin
              miso    <= resp_sr[39];
              resp_sr <= {resp_sr[38:0], 1'b0};
              if (resp_cnt == resp_last) state <= ST_HUNT;
              else resp_cnt <= resp_cnt + 6'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - directed scoreboard bench for sd_spi_responder
module tb_sd_spi_responder;

  localparam int H = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk  = 1'b0;
  logic        mosi  = 1'b1;
  logic        cs_n0 = 1'b1;
  logic        cs_n1 = 1'b1;
  logic        miso0, cmd_valid0, card_idle0;
  logic [5:0]  cmd_index0;
  logic [31:0] cmd_arg0;
  logic        miso1, cmd_valid1, card_idle1;
  logic [5:0]  cmd_index1;
  logic [31:0] cmd_arg1;

  int total = 0;
  int bad   = 0;
  int exp_cnt0 = 0, exp_cnt1 = 0;
  int seen_cnt0 = 0, seen_cnt1 = 0;
  logic [37:0] seen_cmd0 = '0;

  logic [7:0]  resp_q[$];
  logic [37:0] cmd_q[$];

  always #5 clock = ~clock;

  sd_spi_responder dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n0), .mosi(mosi),
    .miso(miso0), .cmd_valid(cmd_valid0), .cmd_index(cmd_index0),
    .cmd_arg(cmd_arg0), .card_idle(card_idle0)
  );

  sd_spi_responder #(.CHECK_CRC(1'b0)) dut_nocrc (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n1), .mosi(mosi),
    .miso(miso1), .cmd_valid(cmd_valid1), .cmd_index(cmd_index1),
    .cmd_arg(cmd_arg1), .card_idle(card_idle1)
  );

  always @(negedge clock) begin
    if (cmd_valid0) begin
      seen_cnt0 = seen_cnt0 + 1;
      seen_cmd0 = {cmd_index0, cmd_arg0};
    end
    if (cmd_valid1) seen_cnt1 = seen_cnt1 + 1;
  end

  function automatic logic [7:0] crc7_byte(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cs(input int sel, input logic v);
    @(negedge clock);
    if (sel == 0) cs_n0 = v; else cs_n1 = v;
    repeat (4) @(negedge clock);
  endtask

  task automatic spi_bit(input logic b, input int sel, output logic r);
    @(negedge clock);
    mosi = b;
    repeat (H) @(negedge clock);
    r = (sel == 0) ? miso0 : miso1;
    sclk = 1'b1;
    repeat (H) @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int sel, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], sel, r);
      rx[i] = r;
    end
  endtask

  task automatic send_cmd(input string tag, input int sel, input logic [5:0] idx,
                          input logic [31:0] arg, input logic [7:0] crc_xor,
                          input int nresp, input logic [39:0] resp);
    logic [39:0] body;
    logic [47:0] fr;
    logic [7:0]  rx, e;
    logic [37:0] ec;
    body = {2'b01, idx, arg};
    fr   = {body, crc7_byte(body) ^ crc_xor};
    resp_q.push_back(8'hFF);
    for (int i = 0; i < nresp; i++) resp_q.push_back(resp[39 - 8*i -: 8]);
    if (sel == 0) begin
      cmd_q.push_back({idx, arg});
      exp_cnt0++;
    end else begin
      exp_cnt1++;
    end
    set_cs(sel, 1'b0);
    for (int i = 5; i >= 0; i--) spi_byte(fr[8*i +: 8], sel, rx);
    for (int i = 0; i <= nresp; i++) begin
      spi_byte(8'hFF, sel, rx);
      e = resp_q.pop_front();
      check($sformatf("%s resp byte %0d", tag, i), 40'(rx), 40'(e));
    end
    set_cs(sel, 1'b1);
    if (sel == 0) begin
      ec = cmd_q.pop_front();
      check({tag, " cmd_valid count"}, 40'(seen_cnt0), 40'(exp_cnt0));
      check({tag, " index/arg"}, 40'(seen_cmd0), 40'(ec));
    end else begin
      check({tag, " cmd_valid count"}, 40'(seen_cnt1), 40'(exp_cnt1));
    end
  endtask

  initial begin
    logic [47:0] fr;
    logic [39:0] body;
    logic [7:0]  rx;
    logic [2:0]  rb;
    logic        r;

    repeat (4) @(negedge clock);
    check("reset miso", 40'(miso0), 40'd1);
    check("reset cmd_valid", 40'(cmd_valid0), 40'd0);
    check("reset cmd_index", 40'(cmd_index0), 40'd0);
    check("reset cmd_arg", 40'(cmd_arg0), 40'd0);
    check("reset card_idle", 40'(card_idle0), 40'd1);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    send_cmd("CMD0", 0, 6'd0, 32'h0, 8'h00, 1, 40'h01_00000000);
    check("CMD0 card_idle", 40'(card_idle0), 40'd1);
    send_cmd("CMD8", 0, 6'd8, 32'h000001AA, 8'h00, 5, 40'h01_000001AA);
    send_cmd("CMD0 bad crc", 0, 6'd0, 32'h0, 8'h01, 1, 40'h09_00000000);
    send_cmd("CMD41 no app", 0, 6'd41, 32'h40000000, 8'h00, 1, 40'h05_00000000);
    send_cmd("CMD17 idle", 0, 6'd17, 32'h0, 8'h00, 1, 40'h05_00000000);

    // cs_n raised after 20 command bits
    body = {2'b01, 6'd0, 32'h0};
    fr   = {body, crc7_byte(body)};
    set_cs(0, 1'b0);
    for (int i = 47; i >= 28; i--) spi_bit(fr[i], 0, r);
    @(negedge clock);
    cs_n0 = 1'b1;
    repeat (4) @(negedge clock);
    check("abort miso", 40'(miso0), 40'd1);
    check("abort no cmd_valid", 40'(seen_cnt0), 40'(exp_cnt0));
    send_cmd("CMD0 after abort", 0, 6'd0, 32'h0, 8'h00, 1, 40'h01_00000000);

    send_cmd("CMD55 a", 0, 6'd55, 32'h0, 8'h00, 1, 40'h01_00000000);
    send_cmd("ACMD41 a", 0, 6'd41, 32'h40000000, 8'h00, 1, 40'h01_00000000);
    check("idle after ACMD41 a", 40'(card_idle0), 40'd1);
    send_cmd("CMD55 b", 0, 6'd55, 32'h0, 8'h00, 1, 40'h01_00000000);
    send_cmd("ACMD41 b", 0, 6'd41, 32'h40000000, 8'h00, 1, 40'h00_00000000);
    check("idle after ACMD41 b", 40'(card_idle0), 40'd0);
    send_cmd("CMD58", 0, 6'd58, 32'h0, 8'h00, 5, 40'h00_C0FF8000);
    send_cmd("CMD17 ready", 0, 6'd17, 32'h0, 8'h00, 1, 40'h04_00000000);

    // reset asserted while the CMD58 response is being shifted out
    body = {2'b01, 6'd58, 32'h0};
    fr   = {body, crc7_byte(body)};
    exp_cnt0++;
    set_cs(0, 1'b0);
    for (int i = 5; i >= 0; i--) spi_byte(fr[8*i +: 8], 0, rx);
    spi_byte(8'hFF, 0, rx);
    check("mid-resp filler", 40'(rx), 40'hFF);
    for (int i = 2; i >= 0; i--) begin
      spi_bit(1'b1, 0, r);
      rb[i] = r;
    end
    check("mid-resp R1 top bits", 40'(rb), 40'd0);
    check("mid-resp cmd_valid count", 40'(seen_cnt0), 40'(exp_cnt0));
    check("mid-resp cmd_index", 40'(cmd_index0), 40'd58);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst mid miso", 40'(miso0), 40'd1);
    check("rst mid cmd_valid", 40'(cmd_valid0), 40'd0);
    check("rst mid cmd_index", 40'(cmd_index0), 40'd0);
    check("rst mid cmd_arg", 40'(cmd_arg0), 40'd0);
    check("rst mid card_idle", 40'(card_idle0), 40'd1);
    reset = 1'b0;
    cs_n0 = 1'b1;
    repeat (4) @(negedge clock);

    send_cmd("nocrc CMD0 bad crc", 1, 6'd0, 32'h0, 8'h01, 1, 40'h01_00000000);
    check("nocrc cmd_index", 40'(cmd_index1), 40'd0);
    check("nocrc card_idle", 40'(card_idle1), 40'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SPI-mode SD card responder: the card-side end of the SD command protocol that the processor's SD host controller drives. It deserialises 48-bit command frames from MOSI, checks CRC7, runs a minimal card initialisation state (CMD0/CMD8/CMD55/ACMD41/CMD58), and serialises R1/R3/R7 responses on MISO. It serves as an on-FPGA loopback card for bring-up of the SD controller and as the card model in system benches. All SPI inputs are oversampled in the single system clock domain.

## Interface
Parameters:
- NCR_BYTES, 1: number of 0xFF filler bytes between the command end bit and the first response byte (≥1).
- INIT_POLLS, 2: ACMD41 count required to leave idle; earlier ones answer 0x01.
- OCR, 32'hC0FF8000: value returned in the R3 payload of CMD58.
- CHECK_CRC, 1: when 0, CRC errors are never flagged.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from the host, asynchronous to clock.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  host-to-card data, asynchronous.
- miso  out  1  card-to-host data; idles high.
- cmd_valid  out  1  one-cycle pulse when a complete frame has been received.
- cmd_index  out  6  index of the last received frame.
- cmd_arg  out  32  argument of the last received frame.
- card_idle  out  1  card in idle state (R1 bit 0).

## Operation
- sclk, cs_n, mosi pass through 2-flop synchronisers; a third sclk flop gives rise/fall strobes. SPI mode 0: sample mosi on rise, update miso on fall.
- States: HUNT → CMD → NCR → RESP → HUNT.
- HUNT: miso=1; on rise with cs_n low and mosi=0 (start bit), enter CMD with bit count 1.
- CMD: shift 47 further bits. Bit 1 must be 1; bits [45:40] index, [39:8] arg, [7:1] CRC, bit 0 end. CRC7 (poly x^7+x^3+1, init 0) runs over the first 40 bits. After the 48th bit: pulse cmd_valid, latch cmd_index/cmd_arg, build response, enter NCR.
- Response build (R1 = {0,param,addr,erase_seq,crc_err,illegal,erase_rst,idle}):
  - CRC mismatch (CHECK_CRC=1) or transmission bit 0: R1 = crc_err|idle, no side effects; crc_err takes priority over illegal.
  - CMD0: card_idle←1, ACMD41 counter←0, app flag←0; R1.
  - CMD8: R7 = R1, 0x00, 0x00, {4'h0,arg[11:8]}, arg[7:0].
  - CMD55: set app flag; R1.
  - ACMD41 (index 41 with app flag): counter++; when counter reaches INIT_POLLS, card_idle←0; R1 uses the updated idle.
  - CMD58: R3 = R1, OCR MSB first.
  - Anything else (including 41 without app flag): R1 = illegal|idle.
  - App flag clears after any command other than CMD55.
- NCR: emit NCR_BYTES×8 ones. RESP: emit 1 or 5 bytes MSB first, then HUNT. mosi is ignored in NCR/RESP.
- cs_n high in any state: immediate return to HUNT, miso=1, partial frame discarded, no cmd_valid; card_idle/counters retained.

## Timing
- Reset values: miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, card_idle=1, state HUNT, counters 0, app flag 0.
- Input-to-strobe latency is 3 clocks; sclk high and low phases must each be ≥4 clocks.
- cmd_valid asserts the clock after the rise strobe of bit 47.
- Response MSB appears on miso at the fall strobe following the last filler bit. miso changes only on fall strobes, cs_n deassert, or reset.
- Reset mid-frame or mid-response overrides all state within one clock.

## Structure
- Package sd_pkg: command index constants (CMD0, 8, 41, 55, 58), R1 bit positions, state enum, frame length 48.
- Sub-module sd_crc7: serial CRC7 with clear, enable, and data bit inputs and a 7-bit output, shared later by the host controller.

## Test plan
- CMD0 frame 40 00 00 00 00 95 → cmd_valid with index 0 and arg 0; one 0xFF, then 0x01; card_idle=1.
- CMD8 frame 48 00 00 01 AA 87 → 0xFF, then 01 00 00 01 AA.
- CMD0 with CRC byte 0x94 → 0x09; with CHECK_CRC=0 → 0x01.
- CMD55+ACMD41 twice (INIT_POLLS=2) → 0x01 then 0x00; card_idle falls after the second; a following CMD58 → 00 C0 FF 80 00.
- CMD41 without CMD55 → 0x05; CMD17 → 0x05 in idle, 0x04 after init.
- cs_n raised after 20 command bits → miso=1, no cmd_valid, next full CMD0 answered normally; reset asserted during RESP → all outputs return to reset values next clock.
